// File: rtl/piso_frame_tx_pkg.sv
// Shared types and line levels for the PISO frame transmitter.
package piso_frame_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Frame length in bits: start + data + stop.
  function automatic int frame_bits(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/piso_frame_tx_bit_timer.sv
// Per-bit cycle counter; bit_end marks the last clk cycle of a serial bit.
module piso_frame_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_end = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || bit_end) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/piso_frame_tx.sv
// Byte-in, serial-out frame transmitter: start 0, DATA_W bits LSB first, stop 1.
module piso_frame_tx
  import piso_frame_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              serial_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bit_idx_q, bit_idx_d;
  logic              serial_q, serial_d;
  logic              bit_end, accept, clr;

  assign accept = tx_valid && (state_q == IDLE);
  // Held clear while idle so START always begins on cycle 0 of its bit.
  assign clr    = (state_q == IDLE) || (state_d != state_q);

  piso_frame_tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      IDLE:  if (accept) begin
               state_d   = START;
               shreg_d   = tx_data;
               bit_idx_d = '0;
             end
      START: if (bit_end) begin
               state_d   = DATA;
               bit_idx_d = '0;
             end
      DATA:  if (bit_end) begin
               shreg_d = shreg_q >> 1;
               if (bit_idx_q == LAST_BIT) begin
                 state_d   = STOP;
                 bit_idx_d = '0;
               end else begin
                 bit_idx_d = bit_idx_q + 1'b1;
               end
             end
      STOP:  if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Line level is registered from the next state so it changes with the state.
    serial_d = IDLE_LEVEL;
    case (state_d)
      IDLE:    serial_d = IDLE_LEVEL;
      START:   serial_d = START_BIT;
      DATA:    serial_d = shreg_d[0];
      default: serial_d = STOP_BIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      serial_q  <= IDLE_LEVEL;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      serial_q  <= serial_d;
    end
  end

  assign serial_out = serial_q;
  assign tx_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == STOP) && bit_end;

endmodule

// File: tb/tb_piso_frame_tx.sv
// Directed + random bench for piso_frame_tx at CLKS_PER_BIT=4 and 1.
module tb_piso_frame_tx;

  localparam int CPB_A = 4;
  localparam int CPB_B = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       rdy_a, rdy_b, so_a, so_b, busy_a, busy_b, done_a, done_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  piso_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB_A)) dut_a (
    .clk(clk), .reset(rst), .tx_data(data_a), .tx_valid(valid_a),
    .tx_ready(rdy_a), .serial_out(so_a), .busy(busy_a), .frame_done(done_a)
  );

  piso_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB_B)) dut_b (
    .clk(clk), .reset(rst), .tx_data(data_b), .tx_valid(valid_b),
    .tx_ready(rdy_b), .serial_out(so_b), .busy(busy_b), .frame_done(done_b)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {serial_out, busy, tx_ready, frame_done}
  function automatic logic [3:0] outs(input bit sel);
    return sel ? {so_b, busy_b, rdy_b, done_b} : {so_a, busy_a, rdy_a, done_a};
  endfunction

  task automatic drive(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin valid_b = v; data_b = d; end
    else     begin valid_a = v; data_a = d; end
  endtask

  task automatic idle(input bit sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle", {12'd0, outs(sel)}, 16'h000A);
      @(posedge clk); #1;
    end
  endtask

  // Sends one frame and checks every cycle against the expected bit sequence.
  // pulse_at: frame cycle at which tx_valid pulses with 8'h55; abort_at: cycle to assert reset.
  task automatic tx_frame(input bit sel, input logic [7:0] d, input bit hold,
                          input int pulse_at, input int abort_at);
    int cpb, b, c;
    logic [9:0] bits, sipo, exp_sipo;
    logic       line;
    cpb = sel ? CPB_B : CPB_A;
    bits[0] = 1'b0;
    bits[9] = 1'b1;
    exp_sipo[9] = 1'b0;
    exp_sipo[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bits[i+1]     = d[i];
      exp_sipo[8-i] = d[i];
    end
    sipo = '0;
    drive(sel, 1'b1, d);
    @(posedge clk); #1;
    if (!hold) drive(sel, 1'b0, d);
    for (int k = 0; k < 10 * cpb; k++) begin
      b = k / cpb;
      c = k % cpb;
      if (k == pulse_at) drive(sel, 1'b1, 8'h55);
      if (pulse_at >= 0 && k == pulse_at + 1) drive(sel, 1'b0, 8'h55);
      if (k == abort_at) begin
        rst = 1'b1;
        #1;
        chk("async reset", {12'd0, outs(sel)}, 16'h000A);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        return;
      end
      @(negedge clk);
      chk("frame cycle", {12'd0, outs(sel)},
          {12'd0, bits[b], 1'b1, 1'b0, (k == 10 * cpb - 1)});
      line = sel ? so_b : so_a;
      if (c == cpb / 2) sipo = {sipo[8:0], line};
      @(posedge clk); #1;
    end
    chk("loopback", {6'd0, sipo}, {6'd0, exp_sipo});
    @(negedge clk);
    chk("idle gap", {12'd0, outs(sel)}, 16'h000A);
  endtask

  initial begin
    bit hold;
    rst = 1'b1;
    valid_a = 1'b0; valid_b = 1'b0;
    data_a = '0;    data_b = '0;
    #1;
    chk("reset a", {12'd0, outs(1'b0)}, 16'h000A);
    chk("reset b", {12'd0, outs(1'b1)}, 16'h000A);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    idle(1'b0, 2);

    tx_frame(1'b0, 8'hA5, 1'b0, -1, -1);
    idle(1'b0, 2);

    // Back-to-back with tx_valid held high across both frames.
    tx_frame(1'b0, 8'h00, 1'b1, -1, -1);
    tx_frame(1'b0, 8'hFF, 1'b0, -1, -1);
    idle(1'b0, 3);

    // Reset during the third data bit, then a clean frame.
    tx_frame(1'b0, 8'h3C, 1'b0, -1, 3 * CPB_A + 1);
    idle(1'b0, 2);
    tx_frame(1'b0, 8'h81, 1'b0, -1, -1);

    // tx_valid pulse mid-frame must be ignored.
    tx_frame(1'b0, 8'h0F, 1'b0, 20, -1);
    idle(1'b0, 45);

    tx_frame(1'b1, 8'hC3, 1'b0, -1, -1);
    idle(1'b1, 2);

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 8; i++) begin
        hold = (i < 7) && ($urandom_range(0, 1) == 1);
        tx_frame(s[0], 8'($urandom_range(0, 255)), hold, -1, -1);
      end
      idle(s[0], 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_frame_tx.md
Name: piso_frame_tx

Overview:
- Serial transmitter stage that sits directly upstream of the team's 10-bit SIPO deserializer.
- Accepts one parallel data byte through a valid/ready handshake and emits a 10-bit frame on a single serial line: start bit 0, 8 data bits LSB first, stop bit 1.
- Each bit is held for CLKS_PER_BIT clock cycles.
- Provides the frame format the downstream SIPO captures.

Parameters:
- DATA_W, 8, data bits per frame; frame length is DATA_W+2 bits.
- CLKS_PER_BIT, 16, clk cycles per serial bit (legal range ≥1).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- tx_data  input  DATA_W  byte to send; sampled only on accept
- tx_valid  input  1  producer has a byte
- tx_ready  output  1  block can accept; high only in IDLE
- serial_out  output  1  serial line; idles high
- busy  output  1  frame in progress (START, DATA or STOP)
- frame_done  output  1  one-cycle pulse on the final cycle of the stop bit

Behaviour:
- Reset values:
  - Asserting reset forces the following immediately, mid-frame included; the partial frame is abandoned with no resumption:
    - state IDLE
    - serial_out 1, busy 0, frame_done 0, tx_ready 1
    - bit counter 0, cycle counter 0, shift register 0
- States: IDLE, START, DATA, STOP.
- Accept:
  - Occurs on a rising edge with tx_valid && tx_ready.
  - tx_data is latched into the shift register.
  - Next state is START.
  - serial_out goes 0 in the cycle following the accept edge; this is a registered output.
- Timing:
  - Cycle counter counts 0..CLKS_PER_BIT-1; bit_end = (cycle counter == CLKS_PER_BIT-1).
  - START: drive 0; on bit_end go to DATA with bit index 0.
  - DATA: drive shift_reg[0]. On bit_end, shift right by 1 and increment bit index. Once bit index DATA_W-1 completes, go to STOP.
  - STOP: drive 1; frame_done=1 on the bit_end cycle; on bit_end go to IDLE.
- Frame duration: exactly (DATA_W+2)*CLKS_PER_BIT cycles from the first 0 to the end of the stop bit.
- Back-to-back:
  - tx_ready rises in the first IDLE cycle.
  - If tx_valid is already high, accept happens on that edge, so the inter-frame idle-high gap is exactly 1 cycle.
- tx_valid while busy: ignored; tx_ready=0 and no state change. tx_data changes during a frame do not affect the frame in flight.
- CLKS_PER_BIT=1: bit_end is permanently true, and every state lasts one cycle per bit.
- Counter widths:
  - cycle counter uses $clog2(CLKS_PER_BIT), with a minimum of 1 bit.
  - bit index uses $clog2(DATA_W).
  - Both counters wrap to 0 at state transitions and never overflow.
- busy = (state != IDLE); tx_ready = (state == IDLE); both decoded from registered state.
- Loopback property: a SIPO shifted once per bit mid-period after 10 bits holds the following, with start at bit 9 and stop at bit 0:
  - bit 9 = start
  - bits 8..1 = tx_data[0..7]
  - bit 0 = stop

Decomposition:
- Shared package:
  - state enum (IDLE/START/DATA/STOP)
  - START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1
  - FRAME_BITS=DATA_W+2
- One natural sub-module, bit_timer:
  - Behaviour: the CLKS_PER_BIT cycle counter that produces bit_end.
  - Clear input: clr, driven on accept and at state changes.

Test Plan:
- Single frame: CLKS_PER_BIT=4, send tx_data=8'hA5 → serial_out holds 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles. That is 40 cycles total, with frame_done pulsing on cycle 40 and tx_ready high on cycle 41.
- Back-to-back: tx_valid held high with 8'h00 then 8'hFF → exactly one idle-high cycle between frames; the second frame is 0,1×8,1.
- Reset mid-frame: assert reset during the 3rd data bit of 8'h3C → serial_out=1 and tx_ready=1 asynchronously. After release, 8'h81 transmits correctly with no residue.
- Ignore while busy: pulse tx_valid with 8'h55 during a frame of 8'h0F → only the 8'h0F frame appears and no second frame follows.
- CLKS_PER_BIT=1: send 8'hC3 → 10-cycle frame 0,1,1,0,0,0,0,1,1,1.
- Loopback: connect to the SIPO with its clock enabled at mid-bit, send 8'hA5 → SIPO data_out=10'h14B after 10 bit periods.
